// File: rtl/riscv_mmio_monitor_if.sv
// Memory-stage store stream and console drain port of the MMIO test monitor.
// The master side is the core/consumer, the slave side is the monitor.
interface riscv_mmio_monitor_if #(
    parameter int XLEN = 32
);
    logic            i_mem_write;
    logic [XLEN-1:0] i_addr;
    logic [3:0]      i_byte_sel;
    logic [XLEN-1:0] i_wdata;
    logic            o_char_valid;
    logic [7:0]      o_char;
    logic            i_char_ready;

    modport master (
        output i_mem_write, i_addr, i_byte_sel, i_wdata, i_char_ready,
        input  o_char_valid, o_char
    );

    modport slave (
        input  i_mem_write, i_addr, i_byte_sel, i_wdata, i_char_ready,
        output o_char_valid, o_char
    );
endinterface

// File: rtl/riscv_mmio_monitor.sv
// Passive MMIO test monitor: decodes TOHOST/CONSOLE stores, buffers console
// bytes, counts cycles/stores and raises a watchdog timeout.
module riscv_mmio_monitor #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter logic [XLEN-1:0] CONSOLE_ADDR   = 32'h0000_1004,
    parameter int              FIFO_DEPTH     = 8,
    parameter int              TIMEOUT_CYCLES = 100000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    riscv_mmio_monitor_if.slave    bus,
    output logic                   o_done,
    output logic                   o_pass,
    output logic                   o_timeout,
    output logic [XLEN-2:0]        o_fail_id,
    output logic [31:0]            o_cycle_count,
    output logic [31:0]            o_store_count,
    output logic                   o_char_overflow
);
    localparam int          AW           = $clog2(FIFO_DEPTH);
    localparam int          CW           = AW + 1;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    generate
        if (TOHOST_ADDR == CONSOLE_ADDR) begin : g_addr_clash
            $error("riscv_mmio_monitor: TOHOST_ADDR must differ from CONSOLE_ADDR");
        end
        if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 64) || ((1 << AW) != FIFO_DEPTH)) begin : g_depth_bad
            $error("riscv_mmio_monitor: FIFO_DEPTH must be a power of two in 2..64");
        end
    endgenerate

    state_t          state_r;
    logic            done_r, pass_r, timeout_r, overflow_r, char_valid_r;
    logic [XLEN-2:0] fail_id_r;
    logic [31:0]     cycle_count_r, store_count_r;
    logic [7:0]      fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   fifo_count_r;
    logic [7:0]      char_r;

    logic            run_s, tohost_hit_s, console_hit_s, watchdog_s;
    logic            empty_s, full_s, push_s, pop_s, drop_s;
    logic [CW-1:0]   fifo_count_next_s;
    logic [7:0]      head_next_s;

    // Address decode, watchdog condition and FIFO next-state selection.
    always_comb begin
        run_s         = (state_r == ST_RUN);
        tohost_hit_s  = run_s & bus.i_mem_write & (bus.i_addr == TOHOST_ADDR)
                        & (bus.i_byte_sel == 4'b1111);
        console_hit_s = run_s & bus.i_mem_write & (bus.i_addr == CONSOLE_ADDR)
                        & bus.i_byte_sel[0];
        watchdog_s    = (TIMEOUT_CYCLES != 0) & run_s & ~tohost_hit_s
                        & (cycle_count_r == TIMEOUT_LAST);
        empty_s       = (fifo_count_r == CW'(0));
        full_s        = (fifo_count_r == CW'(FIFO_DEPTH));
        pop_s         = ~empty_s & bus.i_char_ready;
        push_s        = console_hit_s & (~full_s | pop_s);
        drop_s        = console_hit_s & full_s & ~pop_s;

        fifo_count_next_s = fifo_count_r;
        if (push_s && !pop_s) begin
            fifo_count_next_s = fifo_count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            fifo_count_next_s = fifo_count_r - CW'(1);
        end else begin
            fifo_count_next_s = fifo_count_r;
        end

        // The head register mirrors fifo_mem_r[rd_ptr_r]; refill it from the
        // next slot, or from the incoming byte when that byte becomes the head.
        head_next_s = char_r;
        if (pop_s) begin
            if (fifo_count_r == CW'(1)) begin
                head_next_s = push_s ? bus.i_wdata[7:0] : char_r;
            end else begin
                head_next_s = fifo_mem_r[rd_ptr_r + AW'(1)];
            end
        end else if (push_s && empty_s) begin
            head_next_s = bus.i_wdata[7:0];
        end else begin
            head_next_s = char_r;
        end
    end

    // Test status state machine, counters and sticky status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= ST_RUN;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timeout_r     <= 1'b0;
            fail_id_r     <= '0;
            cycle_count_r <= 32'd0;
            store_count_r <= 32'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    cycle_count_r <= cycle_count_r + 32'd1;
                    if (bus.i_mem_write) begin
                        store_count_r <= store_count_r + 32'd1;
                    end
                    if (tohost_hit_s && (bus.i_wdata == XLEN'(1))) begin
                        state_r <= ST_PASS;
                        done_r  <= 1'b1;
                        pass_r  <= 1'b1;
                    end else if (tohost_hit_s && bus.i_wdata[0]) begin
                        state_r   <= ST_FAIL;
                        done_r    <= 1'b1;
                        fail_id_r <= bus.i_wdata[XLEN-1:1];
                    end else if (watchdog_s) begin
                        state_r   <= ST_TIMEOUT;
                        done_r    <= 1'b1;
                        pass_r    <= 1'b0;
                        timeout_r <= 1'b1;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    // Console FIFO pointers, occupancy, registered head and overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
            char_r       <= 8'd0;
            char_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            fifo_count_r <= fifo_count_next_s;
            char_r       <= head_next_s;
            char_valid_r <= (fifo_count_next_s != CW'(0));
        end
    end

    // Console FIFO storage.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= bus.i_wdata[7:0];
        end
    end

    assign o_done           = done_r;
    assign o_pass           = pass_r;
    assign o_timeout        = timeout_r;
    assign o_fail_id        = fail_id_r;
    assign o_cycle_count    = cycle_count_r;
    assign o_store_count    = store_count_r;
    assign o_char_overflow  = overflow_r;
    assign bus.o_char_valid = char_valid_r;
    assign bus.o_char       = char_r;
endmodule

// File: tb/tb_riscv_mmio_monitor.sv
// Directed testbench for riscv_mmio_monitor: default instance for status and
// console checks, a second instance with a 50-cycle watchdog.
module tb_riscv_mmio_monitor;
    localparam logic [31:0] TOHOST  = 32'h0000_1000;
    localparam logic [31:0] CONSOLE = 32'h0000_1004;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_wd;
    logic        done, pass, tmo, ovf;
    logic [30:0] fail_id;
    logic [31:0] cyc, st;
    logic        done_wd, pass_wd, tmo_wd, ovf_wd;
    logic [30:0] fail_id_wd;
    logic [31:0] cyc_wd, st_wd;

    int n_cmp = 0;
    int n_bad = 0;

    riscv_mmio_monitor_if #(.XLEN(32)) bus ();
    riscv_mmio_monitor_if #(.XLEN(32)) bus_wd ();

    riscv_mmio_monitor dut (
        .i_clk(clk), .i_rst(rst), .bus(bus.slave),
        .o_done(done), .o_pass(pass), .o_timeout(tmo), .o_fail_id(fail_id),
        .o_cycle_count(cyc), .o_store_count(st), .o_char_overflow(ovf)
    );

    riscv_mmio_monitor #(.TIMEOUT_CYCLES(50)) dut_wd (
        .i_clk(clk), .i_rst(rst_wd), .bus(bus_wd.slave),
        .o_done(done_wd), .o_pass(pass_wd), .o_timeout(tmo_wd), .o_fail_id(fail_id_wd),
        .o_cycle_count(cyc_wd), .o_store_count(st_wd), .o_char_overflow(ovf_wd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        bus.i_mem_write = 1'b1;
        bus.i_addr      = a;
        bus.i_byte_sel  = s;
        bus.i_wdata     = d;
        tick();
        bus.i_mem_write = 1'b0;
        bus.i_addr      = 32'd0;
        bus.i_byte_sel  = 4'd0;
        bus.i_wdata     = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_char_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        store(CONSOLE, 4'b0001, 32'h0000_0041);
        store(TOHOST, 4'b1111, 32'h0000_0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if ({done, pass, tmo, fail_id, cyc, st, ovf} !== 99'd0) begin
            n_bad++; $display("FAIL reset_status got=%0h exp=0", {done, pass, tmo, fail_id, cyc, st, ovf});
        end
        n_cmp++;
        if ({bus.o_char_valid, bus.o_char} !== 9'd0) begin
            n_bad++; $display("FAIL reset_fifo got=%0h exp=0", {bus.o_char_valid, bus.o_char});
        end
        n_cmp++;
    endtask

    task automatic test_pass();
        do_reset();
        idle(10);
        if (cyc !== 32'd10) begin n_bad++; $display("FAIL pass_pre_cycles got=%0d exp=10", cyc); end
        n_cmp++;
        store(TOHOST, 4'b1111, 32'h0000_0001);
        if ({done, pass, tmo} !== 3'b110) begin
            n_bad++; $display("FAIL pass_status got=%b exp=110", {done, pass, tmo});
        end
        n_cmp++;
        if (cyc !== 32'd11) begin n_bad++; $display("FAIL pass_cycles got=%0d exp=11", cyc); end
        n_cmp++;
        if (st !== 32'd1) begin n_bad++; $display("FAIL pass_stores got=%0d exp=1", st); end
        n_cmp++;
        store(CONSOLE, 4'b0001, 32'h0000_0051);
        idle(1);
        if (bus.o_char_valid !== 1'b0) begin
            n_bad++; $display("FAIL pass_no_push got=%b exp=0", bus.o_char_valid);
        end
        n_cmp++;
        if ({cyc, st} !== {32'd11, 32'd1}) begin
            n_bad++; $display("FAIL pass_frozen got=%0d/%0d exp=11/1", cyc, st);
        end
        n_cmp++;
    endtask

    task automatic test_fail();
        do_reset();
        store(TOHOST, 4'b1111, 32'h0000_000B);
        if ({done, pass, fail_id} !== {1'b1, 1'b0, 31'd5}) begin
            n_bad++; $display("FAIL fail_status got=%b/%b/%0d exp=1/0/5", done, pass, fail_id);
        end
        n_cmp++;
        store(TOHOST, 4'b1111, 32'h0000_0001);
        if ({done, pass, fail_id, st} !== {1'b1, 1'b0, 31'd5, 32'd1}) begin
            n_bad++; $display("FAIL fail_sticky got=%b/%b/%0d/%0d exp=1/0/5/1", done, pass, fail_id, st);
        end
        n_cmp++;
    endtask

    task automatic test_ignored();
        do_reset();
        store(TOHOST, 4'b0001, 32'h0000_0001);
        store(TOHOST, 4'b1111, 32'h0000_0002);
        if ({done, pass, fail_id} !== 33'd0) begin
            n_bad++; $display("FAIL ignored_status got=%b/%b/%0d exp=0/0/0", done, pass, fail_id);
        end
        n_cmp++;
        if ({cyc, st} !== {32'd2, 32'd2}) begin
            n_bad++; $display("FAIL ignored_counts got=%0d/%0d exp=2/2", cyc, st);
        end
        n_cmp++;
    endtask

    task automatic test_fifo_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            store(CONSOLE, 4'b0001, 32'h0000_0041 + 32'(i));
            if (i == 0) begin
                if ({bus.o_char_valid, bus.o_char} !== {1'b1, 8'h41}) begin
                    n_bad++; $display("FAIL fifo_first got=%b/%h exp=1/41", bus.o_char_valid, bus.o_char);
                end
                n_cmp++;
            end
        end
        if (ovf !== 1'b1) begin n_bad++; $display("FAIL fifo_overflow got=%b exp=1", ovf); end
        n_cmp++;
        bus.i_char_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ({bus.o_char_valid, bus.o_char} !== {1'b1, 8'h41 + 8'(i)}) begin
                n_bad++; $display("FAIL fifo_drain_%0d got=%b/%h exp=1/%h", i, bus.o_char_valid, bus.o_char, 8'h41 + 8'(i));
            end
            n_cmp++;
            tick();
        end
        if (bus.o_char_valid !== 1'b0) begin
            n_bad++; $display("FAIL fifo_empty got=%b exp=0", bus.o_char_valid);
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [8];
        do_reset();
        for (int i = 0; i < 8; i++) store(CONSOLE, 4'b0001, 32'h0000_0030 + 32'(i));
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL b2b_full_no_ovf got=%b exp=0", ovf); end
        n_cmp++;
        bus.i_char_ready = 1'b1;
        store(CONSOLE, 4'b0001, 32'h0000_005A);
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf got=%b exp=0", ovf); end
        n_cmp++;
        for (int i = 0; i < 7; i++) exp_b[i] = 8'h31 + 8'(i);
        exp_b[7] = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            if ({bus.o_char_valid, bus.o_char} !== {1'b1, exp_b[i]}) begin
                n_bad++; $display("FAIL b2b_drain_%0d got=%b/%h exp=1/%h", i, bus.o_char_valid, bus.o_char, exp_b[i]);
            end
            n_cmp++;
            tick();
        end
        if (bus.o_char_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_empty got=%b exp=0", bus.o_char_valid);
        end
        n_cmp++;
    endtask

    task automatic test_timeout();
        rst_wd = 1'b1;
        tick();
        rst_wd = 1'b0;
        idle(20);
        if (cyc_wd !== 32'd20) begin n_bad++; $display("FAIL wd_cycles20 got=%0d exp=20", cyc_wd); end
        n_cmp++;
        rst_wd = 1'b1;
        tick();
        rst_wd = 1'b0;
        if (cyc_wd !== 32'd0) begin n_bad++; $display("FAIL wd_restart got=%0d exp=0", cyc_wd); end
        n_cmp++;
        idle(49);
        if ({done_wd, tmo_wd, cyc_wd} !== {2'b00, 32'd49}) begin
            n_bad++; $display("FAIL wd_before got=%b/%b/%0d exp=0/0/49", done_wd, tmo_wd, cyc_wd);
        end
        n_cmp++;
        idle(1);
        if ({done_wd, pass_wd, tmo_wd, cyc_wd} !== {3'b101, 32'd50}) begin
            n_bad++; $display("FAIL wd_fire got=%b/%b/%b/%0d exp=1/0/1/50", done_wd, pass_wd, tmo_wd, cyc_wd);
        end
        n_cmp++;
        idle(3);
        if ({done_wd, cyc_wd} !== {1'b1, 32'd50}) begin
            n_bad++; $display("FAIL wd_frozen got=%b/%0d exp=1/50", done_wd, cyc_wd);
        end
        n_cmp++;
    endtask

    initial begin
        rst                 = 1'b1;
        rst_wd              = 1'b1;
        bus.i_mem_write     = 1'b0;
        bus.i_addr          = 32'd0;
        bus.i_byte_sel      = 4'd0;
        bus.i_wdata         = 32'd0;
        bus.i_char_ready    = 1'b0;
        bus_wd.i_mem_write  = 1'b0;
        bus_wd.i_addr       = 32'd0;
        bus_wd.i_byte_sel   = 4'd0;
        bus_wd.i_wdata      = 32'd0;
        bus_wd.i_char_ready = 1'b0;
        idle(2);
        test_reset();
        test_pass();
        test_fail();
        test_ignored();
        test_fifo_overflow();
        test_back_to_back();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
